// File: rtl/mips_pkg.sv
// Shared constants of the five-stage MIPS pipeline.
// Used by write-back, MEM/WB, forwarding and hazard blocks.
package mips_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;

   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_read_port.sv
// One combinational GPR read port with optional write-to-read bypass.
// Index 0 has no storage entry and always reads zero.
module reg_read_port
   import mips_pkg::*;
#(
   parameter int DW     = DATA_W,
   parameter int AW     = ADDR_W,
   parameter bit NO_BYP = 1'b0
) (
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] regs_i [1:NUM_REGS-1],
   input  logic          byp_en_i,
   input  logic [AW-1:0] byp_addr_i,
   input  logic [DW-1:0] byp_data_i,
   output logic [DW-1:0] data_o
);

   logic is_zero;
   logic hit;

   assign is_zero = (addr_i == '0);
   assign hit     = !NO_BYP && byp_en_i && (byp_addr_i == addr_i);

   always_comb begin
      data_o = '0;
      unique case (1'b1)
         is_zero: data_o = '0;
         hit:     data_o = byp_data_i;
         default: data_o = regs_i[addr_i];
      endcase
   end

endmodule

// File: rtl/wb_reg_file.sv
// Write-back stage: selects the WB value, commits it to the GPR file,
// and serves two bypassed ID read ports plus one committed-state debug port.
module wb_reg_file #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              WB_RegWrite,
   input  logic              WB_MemToReg,
   input  logic [DATA_W-1:0] WB_D2,
   input  logic [DATA_W-1:0] WB_MemData,
   input  logic [ADDR_W-1:0] WB_RD,
   input  logic [ADDR_W-1:0] ID_RS,
   input  logic [ADDR_W-1:0] ID_RT,
   output logic [DATA_W-1:0] ID_D1,
   output logic [DATA_W-1:0] ID_D2,
   output logic [DATA_W-1:0] WB_Data,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [CNT_W-1:0]  wb_count
);

   import mips_pkg::NUM_REGS;
   import mips_pkg::REG_ZERO;

   logic [DATA_W-1:0] gpr_q [1:NUM_REGS-1];
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic              commit;

   assign WB_Data = WB_MemToReg ? WB_MemData : WB_D2;

   // Reset gates the enable so an unreset (X) RegWrite cannot leak through
   assign commit = !reset && WB_RegWrite && (WB_RD != REG_ZERO);
   assign cnt_d  = cnt_q + CNT_W'(1);

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            gpr_q[i] <= '0;
         end
         cnt_q <= '0;
      end else if (commit) begin
         gpr_q[WB_RD] <= WB_Data;
         cnt_q        <= cnt_d;
      end
   end

   assign wb_count = cnt_q;

   reg_read_port #(.DW(DATA_W), .AW(ADDR_W), .NO_BYP(1'b0)) u_rs (
      .addr_i     (ID_RS),
      .regs_i     (gpr_q),
      .byp_en_i   (commit),
      .byp_addr_i (WB_RD),
      .byp_data_i (WB_Data),
      .data_o     (ID_D1)
   );

   reg_read_port #(.DW(DATA_W), .AW(ADDR_W), .NO_BYP(1'b0)) u_rt (
      .addr_i     (ID_RT),
      .regs_i     (gpr_q),
      .byp_en_i   (commit),
      .byp_addr_i (WB_RD),
      .byp_data_i (WB_Data),
      .data_o     (ID_D2)
   );

   reg_read_port #(.DW(DATA_W), .AW(ADDR_W), .NO_BYP(1'b1)) u_dbg (
      .addr_i     (dbg_addr),
      .regs_i     (gpr_q),
      .byp_en_i   (1'b0),
      .byp_addr_i (WB_RD),
      .byp_data_i (WB_Data),
      .data_o     (dbg_data)
   );

endmodule

// File: tb/tb_wb_reg_file.sv
// Directed bench for wb_reg_file: reset, select, bypass, r0, collision, wrap.
module tb_wb_reg_file;

   logic        clk;
   logic        rst;
   logic        rw;
   logic        m2r;
   logic [31:0] d2;
   logic [31:0] md;
   logic [4:0]  rd;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  dbga;
   logic [31:0] id1, id2, wbd, dbgd, cnt;
   logic [31:0] id1_4, id2_4, wbd_4, dbgd_4;
   logic [3:0]  cnt4;

   int ncmp = 0;
   int nerr = 0;
   logic [31:0] exp_cnt;

   wb_reg_file #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
      .clock(clk), .reset(rst), .WB_RegWrite(rw), .WB_MemToReg(m2r),
      .WB_D2(d2), .WB_MemData(md), .WB_RD(rd), .ID_RS(rs), .ID_RT(rt),
      .ID_D1(id1), .ID_D2(id2), .WB_Data(wbd), .dbg_addr(dbga),
      .dbg_data(dbgd), .wb_count(cnt)
   );

   wb_reg_file #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut4 (
      .clock(clk), .reset(rst), .WB_RegWrite(rw), .WB_MemToReg(m2r),
      .WB_D2(d2), .WB_MemData(md), .WB_RD(rd), .ID_RS(rs), .ID_RT(rt),
      .ID_D1(id1_4), .ID_D2(id2_4), .WB_Data(wbd_4), .dbg_addr(dbga),
      .dbg_data(dbgd_4), .wb_count(cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic wr(input logic [4:0] a, input logic sel,
                     input logic [31:0] v2, input logic [31:0] vm);
      rw = 1'b1; rd = a; m2r = sel; d2 = v2; md = vm;
   endtask

   task automatic idle();
      rw = 1'b0; rd = 5'd0; m2r = 1'b0; d2 = '0; md = '0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; rw = 1'bx; rd = 5'd5; rs = 5'd5; d2 = 32'h77;
      @(negedge clk);
      ncmp++;
      if (cnt !== 32'd0) begin
         nerr++; $display("FAIL rst_x_cnt got %h exp 0", cnt);
      end
      ncmp++;
      if (id1 !== 32'd0) begin
         nerr++; $display("FAIL rst_x_id1 got %h exp 0", id1);
      end
      rst = 1'b0; wr(5'd5, 1'b0, 32'h1234, 32'h0);
      @(negedge clk);
      idle(); dbga = 5'd5; #1;
      ncmp++;
      if (dbgd !== 32'h1234) begin
         nerr++; $display("FAIL preload got %h exp 00001234", dbgd);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         dbga = 5'(i); #1;
         ncmp++;
         if (dbgd !== 32'd0) begin
            nerr++; $display("FAIL rst_dbg[%0d] got %h exp 0", i, dbgd);
         end
      end
      ncmp++;
      if (cnt !== 32'd0) begin
         nerr++; $display("FAIL rst_cnt got %h exp 0", cnt);
      end
      exp_cnt = 0;
   endtask

   task automatic test_commit();
      @(negedge clk);
      wr(5'd3, 1'b0, 32'hDEADBEEF, 32'h0BAD0BAD); #1;
      ncmp++;
      if (wbd !== 32'hDEADBEEF) begin
         nerr++; $display("FAIL sel_d2 got %h exp deadbeef", wbd);
      end
      @(negedge clk);
      exp_cnt++;
      wr(5'd4, 1'b1, 32'h11111111, 32'h0000CAFE); #1;
      ncmp++;
      if (wbd !== 32'h0000CAFE) begin
         nerr++; $display("FAIL sel_md got %h exp 0000cafe", wbd);
      end
      @(negedge clk);
      exp_cnt++;
      idle(); m2r = 1'b1; md = 32'h00ABCDEF; dbga = 5'd3; #1;
      ncmp++;
      if (wbd !== 32'h00ABCDEF) begin
         nerr++; $display("FAIL sel_norw got %h exp 00abcdef", wbd);
      end
      ncmp++;
      if (dbgd !== 32'hDEADBEEF) begin
         nerr++; $display("FAIL gpr3 got %h exp deadbeef", dbgd);
      end
      dbga = 5'd4; #1;
      ncmp++;
      if (dbgd !== 32'h0000CAFE) begin
         nerr++; $display("FAIL gpr4 got %h exp 0000cafe", dbgd);
      end
      ncmp++;
      if (cnt !== 32'd2) begin
         nerr++; $display("FAIL cnt2 got %h exp 2", cnt);
      end
   endtask

   task automatic test_bypass();
      @(negedge clk);
      wr(5'd7, 1'b0, 32'h00000011, 32'h0);
      @(negedge clk);
      exp_cnt++;
      wr(5'd7, 1'b0, 32'hA5A5A5A5, 32'h0);
      rs = 5'd7; rt = 5'd7; dbga = 5'd7; #1;
      ncmp++;
      if (id1 !== 32'hA5A5A5A5) begin
         nerr++; $display("FAIL byp_d1 got %h exp a5a5a5a5", id1);
      end
      ncmp++;
      if (id2 !== 32'hA5A5A5A5) begin
         nerr++; $display("FAIL byp_d2 got %h exp a5a5a5a5", id2);
      end
      ncmp++;
      if (dbgd !== 32'h00000011) begin
         nerr++; $display("FAIL byp_dbg_old got %h exp 00000011", dbgd);
      end
      rt = 5'd3; #1;
      ncmp++;
      if (id2 !== 32'hDEADBEEF) begin
         nerr++; $display("FAIL nobyp_d2 got %h exp deadbeef", id2);
      end
      @(negedge clk);
      exp_cnt++;
      idle(); #1;
      ncmp++;
      if (dbgd !== 32'hA5A5A5A5) begin
         nerr++; $display("FAIL byp_dbg_new got %h exp a5a5a5a5", dbgd);
      end
      ncmp++;
      if (id1 !== 32'hA5A5A5A5) begin
         nerr++; $display("FAIL stored_d1 got %h exp a5a5a5a5", id1);
      end
   endtask

   task automatic test_zero();
      @(negedge clk);
      wr(5'd0, 1'b0, 32'hFFFFFFFF, 32'h0);
      rs = 5'd0; rt = 5'd0; #1;
      ncmp++;
      if (id1 !== 32'd0) begin
         nerr++; $display("FAIL r0_byp got %h exp 0", id1);
      end
      @(negedge clk);
      idle(); dbga = 5'd0; #1;
      ncmp++;
      if (dbgd !== 32'd0) begin
         nerr++; $display("FAIL r0_dbg got %h exp 0", dbgd);
      end
      ncmp++;
      if (cnt !== exp_cnt) begin
         nerr++; $display("FAIL r0_cnt got %h exp %h", cnt, exp_cnt);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         wr(5'd10, 1'b0, 32'(i), 32'h0);
         if (i > 1) exp_cnt++;
      end
      @(negedge clk);
      exp_cnt++;
      idle(); dbga = 5'd10; #1;
      ncmp++;
      if (dbgd !== 32'd3) begin
         nerr++; $display("FAIL b2b_val got %h exp 3", dbgd);
      end
      ncmp++;
      if (cnt !== exp_cnt) begin
         nerr++; $display("FAIL b2b_cnt got %h exp %h", cnt, exp_cnt);
      end
   endtask

   task automatic test_collision();
      @(negedge clk);
      rst = 1'b1; wr(5'd9, 1'b0, 32'h55, 32'h0);
      rs = 5'd9; dbga = 5'd9;
      @(negedge clk);
      #1;
      ncmp++;
      if (id1 !== 32'd0) begin
         nerr++; $display("FAIL col_rst_d1 got %h exp 0", id1);
      end
      ncmp++;
      if (dbgd !== 32'd0) begin
         nerr++; $display("FAIL col_gpr9 got %h exp 0", dbgd);
      end
      ncmp++;
      if (cnt !== 32'd0) begin
         nerr++; $display("FAIL col_cnt0 got %h exp 0", cnt);
      end
      rst = 1'b0;
      @(negedge clk);
      idle(); #1;
      ncmp++;
      if (dbgd !== 32'h55) begin
         nerr++; $display("FAIL col_commit got %h exp 55", dbgd);
      end
      ncmp++;
      if (cnt !== 32'd1) begin
         nerr++; $display("FAIL col_cnt1 got %h exp 1", cnt);
      end
   endtask

   task automatic test_wrap();
      @(negedge clk);
      rst = 1'b1; idle();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 17; i++) begin
         wr(5'((i % 31) + 1), 1'b0, 32'(i), 32'h0);
         @(negedge clk);
         if (i == 14) begin
            ncmp++;
            if (cnt4 !== 4'd15) begin
               nerr++; $display("FAIL wrap_max got %h exp f", cnt4);
            end
         end
         if (i == 15) begin
            ncmp++;
            if (cnt4 !== 4'd0) begin
               nerr++; $display("FAIL wrap_zero got %h exp 0", cnt4);
            end
         end
      end
      idle(); #1;
      ncmp++;
      if (cnt4 !== 4'd1) begin
         nerr++; $display("FAIL wrap_cnt4 got %h exp 1", cnt4);
      end
      ncmp++;
      if (cnt !== 32'd17) begin
         nerr++; $display("FAIL wrap_cnt32 got %h exp 11", cnt);
      end
   endtask

   initial begin
      rst = 1'b1; rw = 1'b0; m2r = 1'b0; d2 = '0; md = '0;
      rd = '0; rs = '0; rt = '0; dbga = '0; exp_cnt = '0;
      test_reset();
      test_commit();
      test_bypass();
      test_zero();
      test_back_to_back();
      test_collision();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/wb_reg_file.md
# wb_reg_file

Write-back stage and architectural register file of the five-stage MIPS pipeline; the consumer end of the MEM/WB pipeline register. Each cycle it selects the write-back value from the MEM/WB outputs (pass-through datapath value or data-memory read data), commits it to the addressed GPR, and serves two ID-stage read ports with internal write-to-read bypass. A debug read port and a retired-write counter support the bench and on-board probing.

## Interface
- DATA_W, 32, GPR and datapath width
- ADDR_W, 5, register address width (32 GPRs)
- CNT_W, 32, width of the retired-write counter
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clock
- WB_RegWrite  in  1  write enable from MEM/WB
- WB_MemToReg  in  1  1: write WB_MemData, 0: write WB_D2
- WB_D2  in  DATA_W  pass-through datapath value from MEM/WB
- WB_MemData  in  DATA_W  data-memory read data aligned to the WB stage
- WB_RD  in  ADDR_W  destination register
- ID_RS, ID_RT  in  ADDR_W  read addresses from the ID stage
- ID_D1, ID_D2  out  DATA_W  read data for RS, RT
- WB_Data  out  DATA_W  selected write-back value (fed to the forwarding unit)
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  debug read data (no bypass)
- wb_count  out  CNT_W  number of committed writes since reset

## Operation
- WB_Data = WB_MemToReg ? WB_MemData : WB_D2; combinational, independent of WB_RegWrite.
- Commit: at a rising edge with reset=0, WB_RegWrite=1 and WB_RD≠0, GPR[WB_RD] ← WB_Data and wb_count ← wb_count+1.
- GPR[0] is hardwired zero: writes to it are dropped and not counted; reads of it always return 0, including through the bypass.
- Reads are combinational: ID_Dn = GPR[ID_addr], except bypass: if WB_RegWrite=1, WB_RD≠0, WB_RD=ID_addr and reset=0, ID_Dn = WB_Data. This makes a same-cycle write visible in ID without an extra stall.
- Both read ports may hit the same address and the bypass simultaneously; both return the same value.
- dbg_data = GPR[dbg_addr], committed state only.
- wb_count wraps from 2^CNT_W−1 to 0 without saturating or flagging.

## Timing
- Reset: at a rising edge with reset=1, all 31 writable GPRs ← 0 and wb_count ← 0. Any concurrent write is dropped. While reset=1, the bypass is disabled, so ID_D1, ID_D2 and dbg_data read 0 after the first reset edge.
- Write latency: 1 edge into storage; 0 cycles to ID via bypass; 1 cycle to dbg_data.
- Reset deasserting on an edge where WB_RegWrite=1: that edge is still a reset edge, so the write is lost. The first commit occurs at the first edge with reset sampled low.
- Back-to-back writes to the same register: the last write wins; each write counts.
- Output reset values: ID_D1=ID_D2=dbg_data=0 and wb_count=0. WB_Data follows its inputs combinationally.
- MEM/WB does not reset its control bits. The block must therefore never commit while reset=1, even if WB_RegWrite is X.

## Structure
- Shared package mips_pkg holds DATA_W, ADDR_W, NUM_REGS=32 and REG_ZERO=5'd0. The MEM/WB, forwarding and hazard blocks use the same constants.
- Storage is a flat array of 31 registers, indices 1–31; no entry exists for index 0.
- One sub-module: reg_read_port, instantiated three times. Its parameters are address, storage array, bypass enable/address/data, and a no-bypass flag for the debug port.

## Test plan
- Reset: preload GPR[5]=0x1234 and assert reset for 1 edge → dbg_data reads 0 for all 32 addresses and wb_count=0.
- Commit and select: write WB_RD=3, MemToReg=0, D2=0xDEADBEEF; then write WB_RD=4, MemToReg=1, MemData=0x0000CAFE → after the next edge GPR[3]=0xDEADBEEF, GPR[4]=0x0000CAFE, wb_count=2.
- Bypass: in the same cycle as the write WB_RD=7, data=0xA5A5A5A5, drive ID_RS=ID_RT=7 → both read 0xA5A5A5A5 before the edge, while dbg_data(7) still shows the old value.
- Zero register: write WB_RD=0 with data 0xFFFFFFFF and read ID_RS=0 in the same cycle → ID_D1=0, GPR[0] stays 0, wb_count is unchanged.
- Reset collision: hold WB_RegWrite=1, WB_RD=9, data=0x55 during the last reset edge → GPR[9]=0 and wb_count=0; the next edge with reset low commits the write (wb_count=1).
- Wrap: with CNT_W=4, perform 17 valid writes → wb_count=1.
